// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered, multi-cycle ALU with iterative multiply/divide.
//
// Keeps the 3-bit ULAControl op map of the combinational ULA. Each result is
// registered, and results are presented with a Start/Busy/Done handshake.
//   clk, reset (async, active-high)
//   Start       one-cycle request; SrcA/SrcB/ULAControl sampled on that edge
//   SrcA, SrcB  WIDTH-bit operands
//   ULAControl  000 AND, 001 OR, 010 ADD, 011 MUL, 100 DIV, 101 EQ, 110 SUB, 111 SLT
//   Busy        high from the cycle after Start through the Done cycle
//   Done        one-cycle pulse; outputs change only in this cycle
//   ULAResult   result / MUL low half / DIV quotient
//   ULAResultHi MUL high half / DIV remainder, else 0
//   FlagZ, FlagC, FlagDiv0  zero/compare, carry/borrow, divide-by-zero
// Parameters: WIDTH (>=2), SLT_SIGNED (1: two's-complement SLT).
// Build option: define ULA_DIV_EN to build the iterative divider. Without it,
// op 100 finishes in one cycle with zero results and FlagZ=1.
module ula_multiciclo #(
  parameter int WIDTH      = 8,
  parameter bit SLT_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ULAControl,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ULAResult,
  output logic [WIDTH-1:0] ULAResultHi,
  output logic             FlagZ,
  output logic             FlagC,
  output logic             FlagDiv0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100,
    OP_EQ  = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  typedef enum logic [1:0] {IDLE, EXEC1, ITER, DONE} state_t;

  state_t           state, state_n;
  op_t              op_in, op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] p_hi, p_lo;
  logic [CW-1:0]    cnt;
  logic             iter_req, finish, step;

  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] res_n, hi_n;
  logic             z_n, c_n, d0_n, lt;

  always_comb op_in = op_t'(ULAControl);

  // Divide by zero never enters ITER; it completes through EXEC1.
  always_comb begin
    iter_req = (op_in == OP_MUL);
`ifdef ULA_DIV_EN
    if (op_in == OP_DIV && SrcB != '0) iter_req = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // ITER performs WIDTH steps while cnt counts 0..WIDTH-1. The extra ITER
  // cycle at cnt==WIDTH latches the result. This gives Done at t+WIDTH+2.
  always_comb begin
    state_n = state;
    Busy    = (state != IDLE);
    Done    = (state == DONE);
    finish  = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE:  if (Start) state_n = iter_req ? ITER : EXEC1;
      EXEC1: begin
        state_n = DONE;
        finish  = 1'b1;
      end
      ITER: begin
        if (cnt == LAST) begin
          state_n = DONE;
          finish  = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shift-add multiply: p_hi accumulates, and p_lo holds the multiplier,
  // which shifts out as the product's low half shifts in.
  always_comb msum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);

`ifdef ULA_DIV_EN
  // Restoring divide: p_hi is the partial remainder and p_lo is the dividend.
  // Quotient bits shift into p_lo from the right.
  logic [WIDTH:0]   dshift;
  logic             dge;
  logic [WIDTH-1:0] ddiff;
  always_comb begin
    dshift = {p_hi, p_lo[WIDTH-1]};
    dge    = (dshift >= {1'b0, b_q});
    ddiff  = dshift[WIDTH-1:0] - b_q;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_AND;
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
    end else if (state == IDLE && Start) begin
      a_q  <= SrcA;
      b_q  <= SrcB;
      op_q <= op_in;
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= (op_in == OP_MUL) ? SrcB : SrcA;
    end else if (step) begin
      cnt <= cnt + CW'(1);
      if (op_q == OP_MUL) begin
        p_hi <= msum[WIDTH:1];
        p_lo <= {msum[0], p_lo[WIDTH-1:1]};
      end
`ifdef ULA_DIV_EN
      else if (dge) begin
        p_hi <= ddiff;
        p_lo <= {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        p_hi <= dshift[WIDTH-1:0];
        p_lo <= {p_lo[WIDTH-2:0], 1'b0};
      end
`endif
    end
  end

  always_comb begin
    res_n = '0;
    hi_n  = '0;
    c_n   = 1'b0;
    d0_n  = 1'b0;
    lt    = 1'b0;
    z_n   = 1'b0;
    case (op_q)
      OP_AND: res_n = a_q & b_q;
      OP_OR:  res_n = a_q | b_q;
      OP_ADD: {c_n, res_n} = {1'b0, a_q} + {1'b0, b_q};
      OP_MUL: begin
        res_n = p_lo;
        hi_n  = p_hi;
      end
      OP_DIV: begin
`ifdef ULA_DIV_EN
        if (b_q == '0) begin
          res_n = '1;
          hi_n  = a_q;
          d0_n  = 1'b1;
        end else begin
          res_n = p_lo;
          hi_n  = p_hi;
        end
`endif
      end
      OP_EQ:  res_n = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_SUB: {c_n, res_n} = {1'b0, a_q} - {1'b0, b_q};
      OP_SLT: begin
        lt    = SLT_SIGNED ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
        res_n = {{(WIDTH-1){1'b0}}, lt};
      end
      default: ;
    endcase
    if (op_q == OP_EQ)       z_n = (a_q != b_q);
    else if (op_q == OP_SUB) z_n = (a_q == b_q);
    else                     z_n = (res_n == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ULAResult   <= '0;
      ULAResultHi <= '0;
      FlagZ       <= 1'b0;
      FlagC       <= 1'b0;
      FlagDiv0    <= 1'b0;
    end else if (finish) begin
      ULAResult   <= res_n;
      ULAResultHi <= hi_n;
      FlagZ       <= z_n;
      FlagC       <= c_n;
      FlagDiv0    <= d0_n;
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: 8-bit unsigned-SLT and 16-bit
// signed-SLT instances, directed vectors plus randomized ops vs. a model.
module tb_ula_multiciclo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        st8, st16;
  logic [2:0]  op8, op16;
  logic [7:0]  a8, b8, r8, h8;
  logic [15:0] a16, b16, r16, h16;
  logic        busy8, done8, z8, c8, dz8;
  logic        busy16, done16, z16, c16, dz16;

  ula_multiciclo #(.WIDTH(8), .SLT_SIGNED(1'b0)) d8 (
    .clk(clk), .reset(reset), .Start(st8), .SrcA(a8), .SrcB(b8),
    .ULAControl(op8), .Busy(busy8), .Done(done8), .ULAResult(r8),
    .ULAResultHi(h8), .FlagZ(z8), .FlagC(c8), .FlagDiv0(dz8)
  );

  ula_multiciclo #(.WIDTH(16), .SLT_SIGNED(1'b1)) d16 (
    .clk(clk), .reset(reset), .Start(st16), .SrcA(a16), .SrcB(b16),
    .ULAControl(op16), .Busy(busy16), .Done(done16), .ULAResult(r16),
    .ULAResultHi(h16), .FlagZ(z16), .FlagC(c16), .FlagDiv0(dz16)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        z;
    logic        c;
    logic        d0;
  } outs_t;

  typedef struct {
    bit         s;
    logic [2:0] op;
    logic [15:0] a;
    logic [15:0] b;
    int         poke;
    outs_t      e;
    int         lat;
  } vec_t;

  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_MUL = 3'd3,
                         OP_DIV = 3'd4, OP_EQ = 3'd5, OP_SUB = 3'd6, OP_SLT = 3'd7;

  int    n_checks = 0;
  int    n_fail = 0;
  bit    sel;
  outs_t obs;
  logic  obs_busy, obs_done;
  outs_t last_exp [2];

  always_comb begin
    if (sel) begin
      obs      = {r16, h16, z16, c16, dz16};
      obs_busy = busy16;
      obs_done = done16;
    end else begin
      obs      = {8'h00, r8, 8'h00, h8, z8, c8, dz8};
      obs_busy = busy8;
      obs_done = done8;
    end
  end

  function automatic outs_t mk(input logic [15:0] r, input logic [15:0] h,
                               input logic z, input logic c, input logic d0);
    return {r, h, z, c, d0};
  endfunction

  // Reference model: plain integer arithmetic on masked operands.
  function automatic outs_t model(input int w, input bit sgn, input logic [2:0] op,
                                  input logic [15:0] a, input logic [15:0] b);
    longint mask, ua, ub, r, h, s, sa, sb;
    logic z, c, d0;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    r = 0; h = 0; c = 1'b0; d0 = 1'b0;
    case (op)
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_ADD: begin s = ua + ub; r = s & mask; c = (s > mask); end
      OP_MUL: begin s = ua * ub; r = s & mask; h = (s >> w) & mask; end
      OP_DIV: begin
`ifdef ULA_DIV_EN
        if (ub == 0) begin r = mask; h = ua; d0 = 1'b1; end
        else begin r = ua / ub; h = ua % ub; end
`endif
      end
      OP_EQ:  r = longint'(ua == ub);
      OP_SUB: begin r = (ua - ub) & mask; c = (ua < ub); end
      default: begin
        sa = (sgn && ua > (mask >> 1)) ? ua - mask - 1 : ua;
        sb = (sgn && ub > (mask >> 1)) ? ub - mask - 1 : ub;
        r  = longint'(sa < sb);
      end
    endcase
    if (op == OP_EQ)       z = (ua != ub);
    else if (op == OP_SUB) z = (ua == ub);
    else                   z = (r == 0);
    return {16'(r), 16'(h), z, c, d0};
  endfunction

  function automatic int model_lat(input int w, input logic [2:0] op, input logic [15:0] b);
    if (op == OP_MUL) return w + 2;
`ifdef ULA_DIV_EN
    if (op == OP_DIV && b != 16'd0) return w + 2;
`endif
    return 2;
  endfunction

  task automatic drive(input bit s, input logic st, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    if (s) begin st16 = st; op16 = op; a16 = a; b16 = b; end
    else begin st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
  endtask

  // Issues one request (caller is at a negedge), scrambles operands while busy,
  // pulses a stray Start at cycle 'poke' (0 = none). Returns the outputs seen
  // in the Done cycle, the latency and {busy held, outputs held, idle after}.
  task automatic run(input bit s, input logic [2:0] op, input logic [15:0] a,
                     input logic [15:0] b, input int poke, output outs_t o,
                     output int lat, output logic [2:0] hs);
    bit busy_ok = 1'b1;
    bit held_ok = 1'b1;
    bit idle_after;
    sel = s;
    drive(s, 1'b1, op, a, b);
    @(negedge clk);
    drive(s, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom));
    lat = 1;
    while (!obs_done && lat < 60) begin
      if (!obs_busy) busy_ok = 1'b0;
      if (obs !== last_exp[s]) held_ok = 1'b0;
      drive(s, lat == poke, 3'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
      lat++;
    end
    o = obs;
    if (!obs_busy) busy_ok = 1'b0;
    drive(s, lat == poke, 3'($urandom), 16'($urandom), 16'($urandom));
    @(negedge clk);
    drive(s, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom));
    idle_after = !obs_busy && !obs_done;
    hs = {busy_ok, held_ok, idle_after};
    last_exp[s] = model(s ? 16 : 8, s, op, a, b);
  endtask

  task automatic test_reset();
    outs_t o;
    int lat;
    logic [2:0] hs;
    reset = 1'b1;
    last_exp[0] = '0;
    last_exp[1] = '0;
    drive(0, 1'b0, 3'd0, 16'd0, 16'd0);
    drive(1, 1'b0, 3'd0, 16'd0, 16'd0);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy8, done8, r8, h8, z8, c8, dz8} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset8: got %h, expected 0", {busy8, done8, r8, h8, z8, c8, dz8});
    end
    n_checks++;
    if ({busy16, done16, r16, h16, z16, c16, dz16} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset16: got %h, expected 0", {busy16, done16, r16, h16, z16, c16, dz16});
    end
    run(0, OP_ADD, 16'd200, 16'd100, 0, o, lat, hs);
    n_checks++;
    if (o !== mk(16'd44, 16'd0, 1'b0, 1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL pre_reset_add: got %h, expected %h", o, mk(16'd44, 16'd0, 1'b0, 1'b1, 1'b0));
    end
    // Reset asserted in cycle t+3 of a multiply.
    drive(0, 1'b1, OP_MUL, 16'd255, 16'd255);
    @(negedge clk);
    drive(0, 1'b0, OP_AND, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mul_busy: got %b, expected 1", busy8);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, r8, h8, z8, c8, dz8} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got %h, expected 0", {busy8, done8, r8, h8, z8, c8, dz8});
    end
    @(negedge clk);
    reset = 1'b0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    @(negedge clk);
    run(0, OP_ADD, 16'd3, 16'd4, 0, o, lat, hs);
    n_checks++;
    if (o !== mk(16'd7, 16'd0, 1'b0, 1'b0, 1'b0) || lat != 2 || hs !== 3'b111) begin
      n_fail++;
      $display("FAIL post_reset_add: got %h lat %0d hs %b, expected %h lat 2 hs 111",
               o, lat, hs, mk(16'd7, 16'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_addsub();
    vec_t v [4];
    outs_t o;
    int lat;
    logic [2:0] hs;
    v[0] = '{1'b0, OP_ADD, 16'd200, 16'd100, 0, mk(16'd44, 16'd0, 1'b0, 1'b1, 1'b0), 2};
    v[1] = '{1'b0, OP_SUB, 16'd5, 16'd5, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[2] = '{1'b0, OP_ADD, 16'd255, 16'd1, 0, mk(16'd0, 16'd0, 1'b1, 1'b1, 1'b0), 2};
    v[3] = '{1'b0, OP_SUB, 16'd0, 16'd1, 0, mk(16'd255, 16'd0, 1'b0, 1'b1, 1'b0), 2};
    foreach (v[i]) begin
      run(v[i].s, v[i].op, v[i].a, v[i].b, v[i].poke, o, lat, hs);
      n_checks++;
      if (o !== v[i].e) begin n_fail++; $display("FAIL addsub[%0d] outputs: got %h, expected %h", i, o, v[i].e); end
      n_checks++;
      if (lat != v[i].lat) begin n_fail++; $display("FAIL addsub[%0d] latency: got %0d, expected %0d", i, lat, v[i].lat); end
      n_checks++;
      if (hs !== 3'b111) begin n_fail++; $display("FAIL addsub[%0d] handshake: got %b, expected 111", i, hs); end
    end
  endtask

  task automatic test_mul();
    vec_t v [3];
    outs_t o;
    int lat;
    logic [2:0] hs;
    v[0] = '{1'b0, OP_MUL, 16'd255, 16'd255, 4, mk(16'h0001, 16'h00FE, 1'b0, 1'b0, 1'b0), 10};
    v[1] = '{1'b0, OP_MUL, 16'd0, 16'd37, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 10};
    v[2] = '{1'b1, OP_MUL, 16'hFFFF, 16'h0002, 7, mk(16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0), 18};
    foreach (v[i]) begin
      run(v[i].s, v[i].op, v[i].a, v[i].b, v[i].poke, o, lat, hs);
      n_checks++;
      if (o !== v[i].e) begin n_fail++; $display("FAIL mul[%0d] outputs: got %h, expected %h", i, o, v[i].e); end
      n_checks++;
      if (lat != v[i].lat) begin n_fail++; $display("FAIL mul[%0d] latency: got %0d, expected %0d", i, lat, v[i].lat); end
      n_checks++;
      if (hs !== 3'b111) begin n_fail++; $display("FAIL mul[%0d] handshake: got %b, expected 111", i, hs); end
    end
  endtask

  task automatic test_div();
    vec_t v [5];
    outs_t o;
    int lat;
    logic [2:0] hs;
`ifdef ULA_DIV_EN
    v[0] = '{1'b0, OP_DIV, 16'd100, 16'd7, 0, mk(16'd14, 16'd2, 1'b0, 1'b0, 1'b0), 10};
    v[1] = '{1'b0, OP_DIV, 16'd9, 16'd0, 0, mk(16'h00FF, 16'd9, 1'b0, 1'b0, 1'b1), 2};
    v[2] = '{1'b0, OP_AND, 16'hF0, 16'h0F, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[3] = '{1'b0, OP_DIV, 16'd5, 16'd9, 0, mk(16'd0, 16'd5, 1'b1, 1'b0, 1'b0), 10};
    v[4] = '{1'b1, OP_DIV, 16'hFFFF, 16'h00FF, 0, mk(16'h0101, 16'd0, 1'b0, 1'b0, 1'b0), 18};
`else
    v[0] = '{1'b0, OP_DIV, 16'd100, 16'd7, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[1] = '{1'b0, OP_DIV, 16'd9, 16'd0, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[2] = '{1'b0, OP_AND, 16'hF0, 16'h0F, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[3] = '{1'b0, OP_DIV, 16'd5, 16'd9, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[4] = '{1'b1, OP_DIV, 16'hFFFF, 16'h00FF, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
`endif
    foreach (v[i]) begin
      run(v[i].s, v[i].op, v[i].a, v[i].b, v[i].poke, o, lat, hs);
      n_checks++;
      if (o !== v[i].e) begin n_fail++; $display("FAIL div[%0d] outputs: got %h, expected %h", i, o, v[i].e); end
      n_checks++;
      if (lat != v[i].lat) begin n_fail++; $display("FAIL div[%0d] latency: got %0d, expected %0d", i, lat, v[i].lat); end
      n_checks++;
      if (hs !== 3'b111) begin n_fail++; $display("FAIL div[%0d] handshake: got %b, expected 111", i, hs); end
    end
  endtask

  task automatic test_cmp_logic();
    vec_t v [8];
    outs_t o;
    int lat;
    logic [2:0] hs;
    v[0] = '{1'b0, OP_EQ, 16'h3C, 16'h3C, 0, mk(16'd1, 16'd0, 1'b0, 1'b0, 1'b0), 2};
    v[1] = '{1'b0, OP_EQ, 16'h3C, 16'h3D, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[2] = '{1'b0, OP_SLT, 16'h80, 16'h01, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[3] = '{1'b0, OP_SLT, 16'h01, 16'h80, 0, mk(16'd1, 16'd0, 1'b0, 1'b0, 1'b0), 2};
    v[4] = '{1'b1, OP_SLT, 16'h8000, 16'h0001, 0, mk(16'd1, 16'd0, 1'b0, 1'b0, 1'b0), 2};
    v[5] = '{1'b1, OP_SLT, 16'h0001, 16'h8000, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    v[6] = '{1'b0, OP_AND, 16'hF0, 16'h3C, 0, mk(16'h30, 16'd0, 1'b0, 1'b0, 1'b0), 2};
    v[7] = '{1'b1, OP_OR, 16'h0000, 16'h0000, 0, mk(16'd0, 16'd0, 1'b1, 1'b0, 1'b0), 2};
    foreach (v[i]) begin
      run(v[i].s, v[i].op, v[i].a, v[i].b, v[i].poke, o, lat, hs);
      n_checks++;
      if (o !== v[i].e) begin n_fail++; $display("FAIL cmp[%0d] outputs: got %h, expected %h", i, o, v[i].e); end
      n_checks++;
      if (lat != v[i].lat) begin n_fail++; $display("FAIL cmp[%0d] latency: got %0d, expected %0d", i, lat, v[i].lat); end
      n_checks++;
      if (hs !== 3'b111) begin n_fail++; $display("FAIL cmp[%0d] handshake: got %b, expected 111", i, hs); end
    end
  endtask

  // Start in the Done cycle must be ignored; the next request from IDLE runs.
  task automatic test_back_to_back();
    vec_t v [4];
    outs_t o;
    int lat;
    logic [2:0] hs;
    v[0] = '{1'b1, OP_ADD, 16'h8000, 16'h8000, 2, mk(16'd0, 16'd0, 1'b1, 1'b1, 1'b0), 2};
    v[1] = '{1'b1, OP_OR, 16'h1234, 16'h00F0, 0, mk(16'h12F4, 16'd0, 1'b0, 1'b0, 1'b0), 2};
    v[2] = '{1'b1, OP_MUL, 16'hFFFF, 16'h0002, 18, mk(16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0), 18};
    v[3] = '{1'b1, OP_EQ, 16'h0007, 16'h0007, 0, mk(16'd1, 16'd0, 1'b0, 1'b0, 1'b0), 2};
    foreach (v[i]) begin
      run(v[i].s, v[i].op, v[i].a, v[i].b, v[i].poke, o, lat, hs);
      n_checks++;
      if (o !== v[i].e) begin n_fail++; $display("FAIL b2b[%0d] outputs: got %h, expected %h", i, o, v[i].e); end
      n_checks++;
      if (lat != v[i].lat) begin n_fail++; $display("FAIL b2b[%0d] latency: got %0d, expected %0d", i, lat, v[i].lat); end
      n_checks++;
      if (hs !== 3'b111) begin n_fail++; $display("FAIL b2b[%0d] handshake: got %b, expected 111", i, hs); end
    end
  endtask

  task automatic test_random();
    outs_t o, e;
    int lat, el, w, poke;
    logic [2:0] hs, op;
    logic [15:0] a, b;
    bit s;
    for (int i = 0; i < 60; i++) begin
      s  = ($urandom_range(0, 2) != 0);
      op = 3'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 5) == 0) b = 16'd0;
      if ($urandom_range(0, 5) == 0) b = a;
      if (!s) begin a = a & 16'h00FF; b = b & 16'h00FF; end
      w  = s ? 16 : 8;
      el = model_lat(w, op, b);
      case ($urandom_range(0, 3))
        1:       poke = el;
        2:       poke = $urandom_range(1, el - 1);
        default: poke = 0;
      endcase
      e = model(w, s, op, a, b);
      run(s, op, a, b, poke, o, lat, hs);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rand[%0d] w%0d op%0d a=%h b=%h outputs: got %h, expected %h", i, w, op, a, b, o, e);
      end
      n_checks++;
      if (lat != el) begin n_fail++; $display("FAIL rand[%0d] latency: got %0d, expected %0d", i, lat, el); end
      n_checks++;
      if (hs !== 3'b111) begin n_fail++; $display("FAIL rand[%0d] handshake: got %b, expected 111", i, hs); end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_cmp_logic();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
